// File: rtl/hazard_sched_ctrl_pkg.sv
// rtl/hazard_sched_ctrl_pkg.sv - shared FSM encodings and parameter defaults for the hazard scheduler
package hazard_sched_ctrl_pkg;

  typedef enum logic [1:0] {
    HS_RUN     = 2'd0,
    HS_MD_BUSY = 2'd1,
    HS_MD_DONE = 2'd2
  } hs_state_e;

  localparam int MD_TIMEOUT_DEFAULT = 64;
  localparam int CNT_W_DEFAULT      = 16;

endpackage

// File: rtl/hazard_sched_ctrl_hazard_detect.sv
// rtl/hazard_sched_ctrl_hazard_detect.sv - combinational load-use comparator between ID sources and an EX load
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_wb_load,
  input  logic [4:0] ex_wb_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 never carries a real value, so a load targeting it cannot create a dependency
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_wb_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_wb_rd);
  assign load_use = ex_wb_load && (ex_wb_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_sched_ctrl.sv
// rtl/hazard_sched_ctrl.sv - pipeline stall/flush/bubble scheduler with MUL/DIV sequencing and watchdog
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sched_ctrl
  import hazard_sched_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_wb_load,
  input  logic [4:0]       ex_wb_rd,
  input  logic             ex_mispredict,
  input  logic             ex_is_muldiv,
  input  logic             md_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_start,
  output logic             md_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_lu_stalls,
  output logic [CNT_W-1:0] perf_md_stalls,
  output logic [CNT_W-1:0] perf_flushes
`endif
);

  localparam int               WD_LAST_I = (MD_TIMEOUT > 0) ? (MD_TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(WD_LAST_I);
  localparam logic             WD_EN     = (MD_TIMEOUT > 0);

  hs_state_e        state;
  logic [CNT_W-1:0] wd_cnt;
  logic             load_use;
  logic             in_run;
  logic             in_busy;
  logic             take_flush;
  logic             take_start;
  logic             take_lu;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_wb_load  (ex_wb_load),
    .ex_wb_rd    (ex_wb_rd),
    .load_use    (load_use)
  );

  // Gating with rst keeps every control quiet while reset is held, even if EX still shows a muldiv
  assign in_run     = !rst && (state == HS_RUN);
  assign in_busy    = !rst && (state == HS_MD_BUSY);
  assign take_flush = in_run && ex_mispredict;
  assign take_start = in_run && !ex_mispredict && ex_is_muldiv;
  assign take_lu    = in_run && !ex_mispredict && !ex_is_muldiv && load_use;

  assign pc_stall      = take_start || take_lu || in_busy;
  assign if_id_stall   = take_start || take_lu || in_busy;
  assign if_id_flush   = take_flush;
  assign id_ex_stall   = take_start || in_busy;
  assign id_ex_flush   = take_flush || take_lu;
  assign ex_mem_bubble = take_start || in_busy;
  assign md_start      = take_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HS_RUN;
      wd_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      case (state)
        HS_RUN: begin
          if (take_start) begin
            state  <= HS_MD_BUSY;
            wd_cnt <= '0;
          end
        end
        HS_MD_BUSY: begin
          if (md_done) begin
            state <= HS_MD_DONE;
          end else if (WD_EN && (wd_cnt == WD_LAST)) begin
            // Abandon the op; the EX instruction leaves with whatever the unit holds
            md_timeout <= 1'b1;
            state      <= HS_RUN;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        HS_MD_DONE: state <= HS_RUN;
        default:    state <= HS_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_stalls <= '0;
      perf_md_stalls <= '0;
      perf_flushes   <= '0;
    end else begin
      if (take_lu && (perf_lu_stalls != '1))
        perf_lu_stalls <= perf_lu_stalls + 1'b1;
      if ((take_start || in_busy) && (perf_md_stalls != '1))
        perf_md_stalls <= perf_md_stalls + 1'b1;
      if (take_flush && (perf_flushes != '1))
        perf_flushes <= perf_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// tb/tb_hazard_sched_ctrl.sv - directed self-checking bench for hazard_sched_ctrl (watchdog set to 8 cycles)
module tb_hazard_sched_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_wb_load;
  logic [4:0] ex_wb_rd;
  logic       ex_mispredict;
  logic       ex_is_muldiv;
  logic       md_done;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       ex_mem_bubble;
  logic       md_start;
  logic       md_timeout;

  int errors = 0;
  int checks = 0;

  // Output vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble, md_start, md_timeout
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_LU    = 8'b1100_1000;
  localparam logic [7:0] O_FLUSH = 8'b0010_1000;
  localparam logic [7:0] O_START = 8'b1101_0110;
  localparam logic [7:0] O_BUSY  = 8'b1101_0100;
  localparam logic [7:0] O_TO    = 8'b0000_0001;
  localparam logic [7:0] O_LU_TO = 8'b1100_1001;

  hazard_sched_ctrl #(.MD_TIMEOUT(8), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_wb_load    (ex_wb_load),
    .ex_wb_rd      (ex_wb_rd),
    .ex_mispredict (ex_mispredict),
    .ex_is_muldiv  (ex_is_muldiv),
    .md_done       (md_done),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_stall   (id_ex_stall),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_bubble (ex_mem_bubble),
    .md_start      (md_start),
    .md_timeout    (md_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    #1;
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
           id_ex_flush, ex_mem_bubble, md_start, md_timeout};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_wb_load = 1'b0; ex_wb_rd = 5'd0; ex_mispredict = 1'b0;
    ex_is_muldiv = 1'b0; md_done = 1'b0;
  endtask

  task automatic set_lu();
    ex_wb_load = 1'b1; ex_wb_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd1; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    chk("reset_idle", O_IDLE);
    ex_is_muldiv = 1'b1;
    chk("reset_muldiv_masked", O_IDLE);
    tick();
    ex_is_muldiv = 1'b0;
    rst = 1'b0;
    chk("after_reset", O_IDLE);

    // lw x5 in EX, add x6,x5,x1 in ID
    set_lu();
    chk("lu_rs1", O_LU);
    tick();
    ex_wb_load = 1'b0;
    chk("lu_bubble_next", O_IDLE);
    tick();

    clear_inputs();
    ex_wb_load = 1'b1; ex_wb_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    chk("lu_rs2", O_LU);
    id_uses_rs2 = 1'b0;
    chk("lu_rs2_unused", O_IDLE);

    clear_inputs();
    ex_wb_load = 1'b1; ex_wb_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    chk("lu_x0", O_IDLE);
    tick();

    clear_inputs();
    set_lu();
    ex_mispredict = 1'b1;
    chk("mispredict_over_lu", O_FLUSH);
    tick();
    clear_inputs();
    ex_mispredict = 1'b1; ex_is_muldiv = 1'b1;
    chk("mispredict_over_muldiv", O_FLUSH);
    tick();
    clear_inputs();
    set_lu();
    chk("still_run_after_mp", O_LU);
    tick();

    // DIV, md_done returned during the 5th busy cycle
    clear_inputs();
    ex_is_muldiv = 1'b1;
    chk("div_c0_start", O_START);
    tick();
    for (int i = 1; i <= 5; i++) begin
      md_done = (i == 5);
      chk($sformatf("div_c%0d_busy", i), O_BUSY);
      tick();
    end
    md_done = 1'b0;
    chk("div_c6_done_no_start", O_IDLE);
    tick();
    ex_is_muldiv = 1'b0;
    set_lu();
    chk("div_c7_run", O_LU);
    tick();

    clear_inputs();
    md_done = 1'b1;
    chk("md_done_in_run", O_IDLE);
    tick();
    md_done = 1'b0;
    set_lu();
    chk("md_done_run_ignored", O_LU);
    tick();

    // Watchdog: 8 busy cycles without md_done
    clear_inputs();
    ex_is_muldiv = 1'b1;
    chk("wd_start", O_START);
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("wd_busy%0d", i), O_BUSY);
      tick();
    end
    ex_is_muldiv = 1'b0;
    chk("wd_timeout_set", O_TO);
    set_lu();
    chk("wd_run_after_timeout", O_LU_TO);
    tick();
    clear_inputs();
    chk("wd_sticky", O_TO);
    rst = 1'b1;
    chk("wd_rst_clears", O_IDLE);
    tick();
    rst = 1'b0;
    chk("wd_after_rst", O_IDLE);

    // Reset in the 2nd busy cycle
    ex_is_muldiv = 1'b1;
    chk("mid_rst_start", O_START);
    tick();
    chk("mid_rst_busy1", O_BUSY);
    tick();
    chk("mid_rst_busy2", O_BUSY);
    rst = 1'b1;
    chk("mid_rst_asserted", O_IDLE);
    tick();
    rst = 1'b0;
    ex_is_muldiv = 1'b0;
    md_done = 1'b1;
    chk("mid_rst_late_done", O_IDLE);
    tick();
    md_done = 1'b0;
    set_lu();
    chk("mid_rst_run", O_LU);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
- Central pipeline scheduler for the 5-stage RV32IM core.
- Decides each cycle whether PC, IF/ID, ID/EX and EX/MEM advance, stall or take a bubble.
- Sources of hazard:
  - load-use hazard, detected from ID and EX register fields;
  - branch mispredict resolved in EX;
  - multi-cycle MUL/DIV unit sequenced with a start/done handshake.
- The ID/EX `pipeline_flush` input is driven solely by this block.

Parameters:
- MD_TIMEOUT, 64, cycles in MD_BUSY before the watchdog aborts; 0 disables the watchdog.
- CNT_W, 16, width of the watchdog counter and the perf counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_wb_load  in  1  EX instruction is a load
- ex_wb_rd  in  5  EX destination register
- ex_mispredict  in  1  EX branch/jump outcome differs from prediction
- ex_is_muldiv  in  1  EX instruction is a multi-cycle M-extension op
- md_done  in  1  MUL/DIV result valid (single-cycle pulse)
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  bubble into ID/EX (drives `pipeline_flush`)
- ex_mem_bubble  out  1  EX/MEM captures a NOP
- md_start  out  1  one-cycle start pulse to the MUL/DIV unit
- md_timeout  out  1  sticky watchdog error flag

Behaviour:
- FSM states: RUN, MD_BUSY, MD_DONE. State resets to RUN.
- Reset values: all outputs 0. State, counters and md_timeout cleared. Reset mid-MD_BUSY returns to RUN immediately and emits no md_start.
- Outputs are a combinational function of the registered state and the current inputs. Zero-cycle decision latency.
- load_use = ex_wb_load & (ex_wb_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_wb_rd) | (id_uses_rs2 & id_rs2 == ex_wb_rd)).
- RUN priority, highest first:
  1. ex_mispredict: if_id_flush = 1, id_ex_flush = 1, no stalls. load_use is ignored because its ID instruction is squashed.
  2. ex_is_muldiv: md_start = 1, pc_stall = if_id_stall = id_ex_stall = 1, ex_mem_bubble = 1. Next state MD_BUSY.
  3. load_use: pc_stall = if_id_stall = 1, id_ex_flush = 1. Exactly one bubble; the following cycle re-evaluates.
  4. Otherwise all outputs 0.
- MD_BUSY:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_bubble held at 1; md_start = 0.
  - Watchdog counter increments each cycle.
  - md_done = 1 → MD_DONE.
  - Counter reaches MD_TIMEOUT−1 without md_done → set md_timeout, go to RUN. The instruction advances with an undefined result.
- MD_DONE:
  - All stall/bubble outputs 0, so the muldiv instruction moves to MEM with its result.
  - md_start is suppressed even though ex_is_muldiv may still read 1 this cycle.
  - Unconditional transition to RUN.
- md_done while in RUN or MD_DONE is ignored.
- ex_mispredict and ex_is_muldiv are mutually exclusive by ISA. If both are asserted, mispredict wins.
- Watchdog counter clears on entry to MD_BUSY. The counter saturates, never wraps.
- A load-use stall never lasts more than 1 cycle for the same EX load, because the bubble clears ex_wb_load.

Optional Feature:
- Macro `HAZARD_PERF_CNT_EN`.
- Defined: three CNT_W-bit saturating counters plus outputs perf_lu_stalls, perf_md_stalls and perf_flushes. Each is reset to 0 and increments per cycle of, respectively, load-use bubble, MD_BUSY/RUN-start stall, and mispredict flush.
- Undefined: neither the counters nor their ports exist, and the remaining behaviour is identical.

Decomposition:
- Shared defines file: FSM state encodings (HS_RUN = 2'd0, HS_MD_BUSY = 2'd1, HS_MD_DONE = 2'd2) and the default for MD_TIMEOUT.
- One natural sub-module: hazard_detect, the purely combinational load_use comparator, reused by the forwarding unit.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 (ex_wb_rd = 5, id_rs1 = 5) → one cycle with pc_stall = if_id_stall = id_ex_flush = 1. Next cycle all 0.
- x0 load: ex_wb_rd = 0, id_rs1 = 0, ex_wb_load = 1 → no stall.
- Mispredict together with load-use in the same cycle → if_id_flush = id_ex_flush = 1, pc_stall = 0.
- DIV with md_done returned after 5 cycles:
  - cycle 0: md_start = 1 plus stalls;
  - cycles 1–5: stalls held, md_start = 0;
  - cycle 6: MD_DONE with all outputs 0;
  - cycle 7: RUN.
- Watchdog with MD_TIMEOUT = 8 and md_done never asserted → md_timeout = 1 after 8 MD_BUSY cycles, state RUN. A later rst clears it.
- rst asserted in the 2nd MD_BUSY cycle → all outputs 0 immediately. After release, RUN, and a late md_done pulse is ignored.
